// File: rtl/caller_pkg.sv
// caller_pkg: shared state encoding, LFSR tap masks and phase period helper
// for random_caller_multi and its lfsr_core.
package caller_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_COUNT = 3'd1,
      ST_LOAD  = 3'd2,
      ST_RUN   = 3'd3,
      ST_STOP  = 3'd4
   } state_e;

   // Fibonacci tap mask, bit i set means stage i+1 feeds the XOR.
   // Supported widths: 16 (16:15:13:4), 25 (25:22), 32 (32:22:2:1).
   function automatic logic [31:0] lfsr_taps(input int unsigned w);
      logic [31:0] m;
      m = '0;
      case (w)
         16: begin
            m[15] = 1'b1;
            m[14] = 1'b1;
            m[12] = 1'b1;
            m[3]  = 1'b1;
         end
         32: begin
            m[31] = 1'b1;
            m[21] = 1'b1;
            m[1]  = 1'b1;
            m[0]  = 1'b1;
         end
         default: begin
            m[24] = 1'b1;
            m[21] = 1'b1;
         end
      endcase
      return m;
   endfunction

   // Cycles per value in phase k; earlier phases are slower.
   function automatic logic [31:0] period(
      input logic [31:0] base,
      input int unsigned nph,
      input logic [2:0]  k
   );
      int unsigned sh;
      sh = nph - 1 - 32'(k);
      return base << sh;
   endfunction

endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: free-running Fibonacci LFSR with synchronous parallel load.
// Ports: i_clk, i_rst_n (async low), i_load, i_seed[LFSR_W], o_data[LFSR_W].
module lfsr_core
   import caller_pkg::*;
#(
   parameter int LFSR_W = 25
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_load,
   input  logic [LFSR_W-1:0] i_seed,
   output logic [LFSR_W-1:0] o_data
);

   localparam logic [31:0] TAPS = lfsr_taps(LFSR_W);

   logic [LFSR_W-1:0] lfsr_q;
   logic              fb;

   assign fb     = ^(lfsr_q & TAPS[LFSR_W-1:0]);
   assign o_data = lfsr_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         lfsr_q <= LFSR_W'(1);
      end else if (i_load) begin
         lfsr_q <= i_seed;
      end else begin
         lfsr_q <= {lfsr_q[LFSR_W-2:0], fb};
      end
   end

endmodule

// File: rtl/random_caller_multi.sv
// random_caller_multi: key-press seeded random caller with decelerating phases.
// Ports: i_clk, i_rst_n (async low), i_start (active-low key), i_max[OUT_W];
//        o_random_out[OUT_W], o_valid, o_done, o_state[3].
// Option: define CALLER_NO_REPEAT_EN to suppress back-to-back repeated values.
module random_caller_multi
   import caller_pkg::*;
#(
   parameter int OUT_W       = 8,
   parameter int LFSR_W      = 25,
   parameter int SEED_W      = 26,
   parameter int NUM_PHASES  = 3,
   parameter int STEPS       = 5,
   parameter int BASE_PERIOD = 5000000
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [OUT_W-1:0] i_max,
   output logic [OUT_W-1:0] o_random_out,
   output logic             o_valid,
   output logic             o_done,
   output logic [2:0]       o_state
);

   localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

   state_e state_q, state_d;

   logic [SEED_W-1:0] seed_q;
   logic [OUT_W-1:0]  max_q;
   logic [OUT_W-1:0]  out_q;
   logic              valid_q;
   logic              done_q;
   logic [31:0]       per_q;
   logic [31:0]       cur_per;
   logic [STEP_W-1:0] step_q;
   logic [2:0]        phase_q;

   logic [LFSR_W-1:0] lfsr;
   logic [LFSR_W-1:0] seed_ext;
   logic [SEED_W+LFSR_W-1:0] seed_wide;
   logic              lfsr_unused;

   logic ld, run, seed_clr, cnt_en, max_ld;
   logic fire, last_step, last_phase, fin;

   logic [OUT_W-1:0] raw, v_lim, v_fin;
   logic [OUT_W:0]   mp1, diff;

   // Seed: low LFSR_W bits, zero-extended, bit0 forced so the LFSR never locks.
   assign seed_wide = {{LFSR_W{1'b0}}, seed_q};
   always_comb begin
      seed_ext    = seed_wide[LFSR_W-1:0];
      seed_ext[0] = 1'b1;
   end

   lfsr_core #(
      .LFSR_W (LFSR_W)
   ) u_lfsr (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (ld),
      .i_seed  (seed_ext),
      .o_data  (lfsr)
   );

   assign raw         = lfsr[OUT_W-1:0];
   assign lfsr_unused = ^lfsr[LFSR_W-1:OUT_W];

   // state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (!i_start) state_d = ST_COUNT;
         ST_COUNT: if (i_start)  state_d = ST_LOAD;
         ST_LOAD:  state_d = ST_RUN;
         ST_RUN:   if (fin)      state_d = ST_STOP;
         ST_STOP:  if (!i_start) state_d = ST_COUNT;
         default:  state_d = ST_IDLE;
      endcase
   end

   // output / strobe logic
   always_comb begin
      ld         = (state_q == ST_LOAD);
      run        = (state_q == ST_RUN);
      seed_clr   = ((state_q == ST_IDLE) || (state_q == ST_STOP)) && !i_start;
      cnt_en     = (state_q == ST_COUNT) && !i_start;
      max_ld     = (state_q == ST_COUNT) && i_start;
      cur_per    = period(32'(BASE_PERIOD), NUM_PHASES, phase_q);
      fire       = run && (per_q == cur_per - 32'd1);
      last_step  = (step_q == STEP_W'(STEPS - 1));
      last_phase = (phase_q == 3'(NUM_PHASES - 1));
      fin        = fire && last_step && last_phase;
   end

   // Range limiter: fold once by (max+1), clamp whatever still overflows.
   always_comb begin
      mp1  = {1'b0, max_q} + (OUT_W+1)'(1);
      diff = {1'b0, raw} - mp1;
      if (raw <= max_q) begin
         v_lim = raw;
      end else if (diff <= {1'b0, max_q}) begin
         v_lim = diff[OUT_W-1:0];
      end else begin
         v_lim = max_q;
      end
   end

`ifdef CALLER_NO_REPEAT_EN
   // A repeat steps to the next value, wrapping to 0 past max_q.
   always_comb begin
      v_fin = v_lim;
      if (v_lim == out_q) begin
         if (v_lim == max_q) v_fin = '0;
         else                v_fin = v_lim + OUT_W'(1);
      end
   end
`else
   assign v_fin = v_lim;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         seed_q  <= '0;
         max_q   <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         per_q   <= '0;
         step_q  <= '0;
         phase_q <= '0;
      end else begin
         if (seed_clr) begin
            seed_q <= '0;
         end else if (cnt_en && (seed_q != '1)) begin
            seed_q <= seed_q + SEED_W'(1);
         end

         if (max_ld) max_q <= i_max;

         valid_q <= fire;
         if (fire) out_q <= v_fin;

         // done follows the final valid pulse and drops with the re-arm edge
         done_q <= (state_q == ST_STOP) && (state_d == ST_STOP);

         if (ld) begin
            per_q   <= '0;
            step_q  <= '0;
            phase_q <= '0;
         end else if (run) begin
            if (fire) begin
               per_q <= '0;
               if (last_step) begin
                  step_q <= '0;
                  if (!last_phase) phase_q <= phase_q + 3'd1;
               end else begin
                  step_q <= step_q + STEP_W'(1);
               end
            end else begin
               per_q <= per_q + 32'd1;
            end
         end
      end
   end

   assign o_random_out = out_q;
   assign o_valid      = valid_q;
   assign o_done       = done_q;
   assign o_state      = state_q;

endmodule
